blit_ram_arb: RTL

// Arbitrates the single 16-bit main-memory port between the CPU RAM path (requests from the bus decoder) and the video refresh fetcher.

---
 rtl/blit_ram_arb_if.sv | 42 ++++
 rtl/blit_ram_arb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/blit_ram_arb_if.sv
// Bus bundle around the main-memory arbiter: CPU RAM path, video fetcher
// and the single memory-controller port.
interface blit_ram_arb_if;
  // CPU RAM path from the bus decoder
  logic        cpu_ram_req;
  logic [17:0] cpu_ram_addr;
  logic [15:0] cpu_ram_wdata;
  logic [1:0]  cpu_ram_wstrb;
  logic        cpu_ram_we;
  logic        cpu_ram_ack;
  logic [15:0] cpu_ram_rdata;
  // Video refresh fetcher
  logic        vid_req;
  logic [16:0] vid_addr;
  logic        vid_valid;
  logic [15:0] vid_data;
  logic        vid_done;
  // Memory controller port
  logic        mem_req;
  logic [16:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wstrb;
  logic        mem_we;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  // Arbiter side: serves both requesters, drives the memory port
  modport slave (
    input  cpu_ram_req, cpu_ram_addr, cpu_ram_wdata, cpu_ram_wstrb, cpu_ram_we,
    input  vid_req, vid_addr, mem_ack, mem_rdata,
    output cpu_ram_ack, cpu_ram_rdata, vid_valid, vid_data, vid_done,
    output mem_req, mem_addr, mem_wdata, mem_wstrb, mem_we
  );

  // Surrounding system side: requesters plus memory controller
  modport master (
    output cpu_ram_req, cpu_ram_addr, cpu_ram_wdata, cpu_ram_wstrb, cpu_ram_we,
    output vid_req, vid_addr, mem_ack, mem_rdata,
    input  cpu_ram_ack, cpu_ram_rdata, vid_valid, vid_data, vid_done,
    input  mem_req, mem_addr, mem_wdata, mem_wstrb, mem_we
  );
endinterface

// File: rtl/blit_ram_arb.sv
// Main-memory arbiter: shares one 16-bit memory port between single-word CPU
// accesses and sequential video bursts, alternating word by word when both
// sources are waiting. BURST_LEN must be >= 1 and 2**CNT_W > BURST_LEN.
module blit_ram_arb #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic          clk,
  input  logic          rstn,
  blit_ram_arb_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_VID} state_e;

  state_e           state_q;
  // Captured CPU request
  logic             cpu_pend_q;
  logic [16:0]      cpu_addr_q;
  logic [15:0]      cpu_wdata_q;
  logic [1:0]       cpu_wstrb_q;
  logic             cpu_we_q;
  // Active video burst
  logic             vid_act_q;
  logic [16:0]      vptr_q;
  logic [CNT_W-1:0] cnt_q;
  // 1 = CPU was granted last, 0 = video was granted last
  logic             last_cpu_q;
  // Registered outputs
  logic             cpu_ack_q;
  logic [15:0]      cpu_rdata_q;
  logic             vid_valid_q;
  logic [15:0]      vid_data_q;
  logic             vid_done_q;
  logic             mem_req_q;
  logic [16:0]      mem_addr_q;
  logic [15:0]      mem_wdata_q;
  logic [1:0]       mem_wstrb_q;
  logic             mem_we_q;

  logic             grant_cpu_d;
  logic             burst_last;
  logic             addr_lsb_unused;

  // Byte lane selection comes from the strobes, so the byte address LSB is dropped
  assign addr_lsb_unused = bus.cpu_ram_addr[0];

  // CPU wins when it is the only requester or when video was served last
  always_comb begin
    grant_cpu_d = cpu_pend_q && (!vid_act_q || !last_cpu_q);
  end

  assign burst_last = (cnt_q == CNT_W'(BURST_LEN - 1));

  // Request capture, arbitration and memory handshake with registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cpu_pend_q  <= 1'b0;
      cpu_addr_q  <= '0;
      cpu_wdata_q <= '0;
      cpu_wstrb_q <= '0;
      cpu_we_q    <= 1'b0;
      vid_act_q   <= 1'b0;
      vptr_q      <= '0;
      cnt_q       <= '0;
      last_cpu_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      vid_done_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_done_q  <= 1'b0;

      // A new pulse is only taken while the source has nothing outstanding
      if (bus.cpu_ram_req && !cpu_pend_q) begin
        cpu_pend_q  <= 1'b1;
        cpu_addr_q  <= bus.cpu_ram_addr[17:1];
        cpu_wdata_q <= bus.cpu_ram_wdata;
        cpu_wstrb_q <= bus.cpu_ram_wstrb;
        cpu_we_q    <= bus.cpu_ram_we;
      end
      if (bus.vid_req && !vid_act_q) begin
        vid_act_q <= 1'b1;
        vptr_q    <= bus.vid_addr;
        cnt_q     <= '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_cpu_d) begin
            state_q     <= ST_CPU;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= cpu_addr_q;
            mem_wdata_q <= cpu_wdata_q;
            mem_wstrb_q <= cpu_wstrb_q;
            mem_we_q    <= cpu_we_q;
          end else if (vid_act_q) begin
            state_q     <= ST_VID;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= vptr_q;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 2'b11;
            mem_we_q    <= 1'b0;
          end
        end
        ST_CPU: begin
          if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= bus.mem_rdata;
            cpu_pend_q  <= 1'b0;
            last_cpu_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_VID: begin
          if (bus.mem_ack) begin
            mem_req_q   <= 1'b0;
            vid_valid_q <= 1'b1;
            vid_data_q  <= bus.mem_rdata;
            vptr_q      <= vptr_q + 17'd1;
            cnt_q       <= cnt_q + CNT_W'(1);
            last_cpu_q  <= 1'b0;
            state_q     <= ST_IDLE;
            if (burst_last) begin
              vid_done_q <= 1'b1;
              vid_act_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cpu_ram_ack   = cpu_ack_q;
  assign bus.cpu_ram_rdata = cpu_rdata_q;
  assign bus.vid_valid     = vid_valid_q;
  assign bus.vid_data      = vid_data_q;
  assign bus.vid_done      = vid_done_q;
  assign bus.mem_req       = mem_req_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wstrb     = mem_wstrb_q;
  assign bus.mem_we        = mem_we_q;

endmodule
